// File: rtl/mano_pkg.sv
// Purpose: shared widths, opcode/register-op codes, sequencer states and decode bundle for the Mano CPU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mano_pkg;

   localparam int WORD_W = 8;
   localparam int ADDR_W = 4;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // Memory-reference opcodes (IR[6:4]); 101 and 110 are NOPs.
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_LDA = 3'b010;
   localparam logic [2:0] OP_STA = 3'b011;
   localparam logic [2:0] OP_BUN = 3'b100;
   localparam logic [2:0] OP_REG = 3'b111;

   // Register-reference codes (IR[3:0] when opcode is OP_REG).
   localparam logic [3:0] RR_CLA = 4'h0;
   localparam logic [3:0] RR_CLE = 4'h1;
   localparam logic [3:0] RR_CMA = 4'h2;
   localparam logic [3:0] RR_CME = 4'h3;
   localparam logic [3:0] RR_INC = 4'h4;
   localparam logic [3:0] RR_SZA = 4'h5;
   localparam logic [3:0] RR_SZE = 4'h6;
   localparam logic [3:0] RR_HLT = 4'h7;

   typedef enum logic [2:0] {
      ST_START,
      ST_FETCH,
      ST_DECODE,
      ST_INDIRECT,
      ST_OPERAND,
      ST_EXEC,
      ST_STORE,
      ST_HALT
   } state_t;

   // One-hot operation select; all zero for NOP encodings.
   typedef struct packed {
      logic mr_and;
      logic mr_add;
      logic mr_lda;
      logic mr_sta;
      logic mr_bun;
      logic rr_cla;
      logic rr_cle;
      logic rr_cma;
      logic rr_cme;
      logic rr_inc;
      logic rr_sza;
      logic rr_sze;
      logic rr_hlt;
   } op_sel_t;

endpackage

// File: rtl/mano_ir_decode.sv
// Purpose: classify an instruction word into memory-/register-reference, indirect flag and one-hot op select.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ir (instruction word) -> mem_ref, reg_ref, indirect, sel.
module mano_ir_decode
   import mano_pkg::*;
(
   input  logic [WORD_W-1:0] ir,
   output logic              mem_ref,
   output logic              reg_ref,
   output logic              indirect,
   output op_sel_t           sel
);

   logic [2:0] opc;
   logic [3:0] low;

   assign opc = ir[6:4];
   assign low = ir[3:0];

   always_comb begin
      sel     = '0;
      mem_ref = 1'b0;
      reg_ref = 1'b0;
      case (opc)
         OP_AND: begin mem_ref = 1'b1; sel.mr_and = 1'b1; end
         OP_ADD: begin mem_ref = 1'b1; sel.mr_add = 1'b1; end
         OP_LDA: begin mem_ref = 1'b1; sel.mr_lda = 1'b1; end
         OP_STA: begin mem_ref = 1'b1; sel.mr_sta = 1'b1; end
         OP_BUN: begin mem_ref = 1'b1; sel.mr_bun = 1'b1; end
         OP_REG: begin
            reg_ref = 1'b1;
            case (low)
               RR_CLA:  sel.rr_cla = 1'b1;
               RR_CLE:  sel.rr_cle = 1'b1;
               RR_CMA:  sel.rr_cma = 1'b1;
               RR_CME:  sel.rr_cme = 1'b1;
               RR_INC:  sel.rr_inc = 1'b1;
               RR_SZA:  sel.rr_sza = 1'b1;
               RR_SZE:  sel.rr_sze = 1'b1;
               RR_HLT:  sel.rr_hlt = 1'b1;
               default: ;
            endcase
         end
         default: ;   // 101/110: NOP, neither class, so it never enters the operand path
      endcase
   end

   // The I bit only matters for real memory-reference instructions.
   assign indirect = ir[7] & mem_ref;

endmodule

// File: rtl/mano_control_sequencer.sv
// Purpose: Mano basic-computer sequencer owning PC/AR/IR/DR/AC/E and driving one-hot ALU strobes.
// Latency: reg-ref/BUN 2, STA 3, AND/ADD/LDA 4 cycles from fetch with zero-wait memory; +1 if indirect.
// Backpressure: memory requests held stable until mem_ack; each wait cycle freezes all registers.
// Ports: clk, rst_n, run | mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata/mem_ack |
//        alu_and/alu_add/alu_lda/alu_cma, e, ac, dr, acdata, carry | pc, halted.
module mano_control_sequencer
   import mano_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              alu_and,
   output logic              alu_add,
   output logic              alu_lda,
   output logic              alu_cma,
   output logic              e,
   output logic [WORD_W-1:0] ac,
   output logic [WORD_W-1:0] dr,
   input  logic [WORD_W-1:0] acdata,
   input  logic              carry,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   state_t state_q, state_d;
   addr_t  pc_q, pc_d, ar_q, ar_d;
   word_t  ir_q, ir_d, dr_q, dr_d, ac_q, ac_d;
   logic   e_q, e_d;

   logic    mem_ref, reg_ref, indirect;
   op_sel_t sel;

   mano_ir_decode u_dec (
      .ir       (ir_q),
      .mem_ref  (mem_ref),
      .reg_ref  (reg_ref),
      .indirect (indirect),
      .sel      (sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_START;
         pc_q    <= '0;
         ar_q    <= '0;
         ir_q    <= '0;
         dr_q    <= '0;
         ac_q    <= '0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ar_q    <= ar_d;
         ir_q    <= ir_d;
         dr_q    <= dr_d;
         ac_q    <= ac_d;
         e_q     <= e_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ar_d      = ar_q;
      ir_d      = ir_q;
      dr_d      = dr_q;
      ac_d      = ac_q;
      e_d       = e_q;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      alu_and   = 1'b0;
      alu_add   = 1'b0;
      alu_lda   = 1'b0;
      alu_cma   = 1'b0;
      halted    = 1'b0;

      case (state_q)
         ST_START: state_d = ST_FETCH;

         ST_FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = pc_q;
            if (mem_ack) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + addr_t'(1);
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            ar_d    = ir_q[3:0];
            state_d = ST_FETCH;
            if (reg_ref) begin
               if (sel.rr_cla) ac_d = '0;
               if (sel.rr_cle) e_d = 1'b0;
               if (sel.rr_cma) begin
                  alu_cma = 1'b1;
                  ac_d    = acdata;
               end
               if (sel.rr_cme) e_d = ~e_q;
               if (sel.rr_inc) ac_d = ac_q + word_t'(1);
               // Skips advance the already-incremented PC, wrapping mod 16.
               if ((sel.rr_sza && (ac_q == '0)) || (sel.rr_sze && !e_q))
                  pc_d = pc_q + addr_t'(1);
               if (sel.rr_hlt) state_d = ST_HALT;
            end else if (mem_ref) begin
               if (indirect)        state_d = ST_INDIRECT;
               else if (sel.mr_sta) state_d = ST_STORE;
               else if (sel.mr_bun) pc_d = ir_q[3:0];
               else                 state_d = ST_OPERAND;
            end
         end

         ST_INDIRECT: begin
            mem_rd   = 1'b1;
            mem_addr = ar_q;
            if (mem_ack) begin
               ar_d = mem_rdata[3:0];
               if (sel.mr_bun) begin
                  pc_d    = mem_rdata[3:0];
                  state_d = ST_FETCH;
               end else if (sel.mr_sta) begin
                  state_d = ST_STORE;
               end else begin
                  state_d = ST_OPERAND;
               end
            end
         end

         ST_OPERAND: begin
            mem_rd   = 1'b1;
            mem_addr = ar_q;
            if (mem_ack) begin
               dr_d    = mem_rdata;
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            // Only AND/ADD/LDA reach here, so exactly one strobe fires.
            alu_and = sel.mr_and;
            alu_add = sel.mr_add;
            alu_lda = sel.mr_lda;
            ac_d    = acdata;
            if (sel.mr_add) e_d = carry;
            state_d = ST_FETCH;
         end

         ST_STORE: begin
            mem_wr    = 1'b1;
            mem_addr  = ar_q;
            mem_wdata = ac_q;
            if (mem_ack) state_d = ST_FETCH;
         end

         ST_HALT: begin
            halted = 1'b1;
            if (run) state_d = ST_FETCH;
         end

         default: state_d = ST_START;
      endcase
   end

   assign pc = pc_q;
   assign ac = ac_q;
   assign dr = dr_q;
   assign e  = e_q;

endmodule
